// File: rtl/domain_demux_reg_if.sv
// Handshake bundle for the domain demultiplexer: one tagged input stream,
// two per-domain output streams and the two status flags.
// The DUT attaches to the slave modport; the producer/consumer side
// (or a testbench) attaches to the master modport.
interface domain_demux_reg_if #(
    parameter int DW = 2
);
    // Input stream
    logic [DW-1:0] in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;

    // Domain-0 output stream
    logic [DW-1:0] out0_data;
    logic          out0_valid;
    logic          out0_ready;

    // Domain-1 output stream
    logic [DW-1:0] out1_data;
    logic          out1_valid;
    logic          out1_ready;

    // Status
    logic          cur_dom;
    logic          scrubbing;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
        input  cur_dom, scrubbing
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid,
        output cur_dom, scrubbing
    );
endinterface

// File: rtl/domain_demux_reg.sv
// Registered two-domain demultiplexer.
// Each word tagged with in_sel is steered through one shared staging
// register to the output port of its domain. Whenever the requested domain
// differs from the one that last owned the stage, the stage is zeroed and
// held in SCRUB for SCRUB_CYCLES cycles (legal range 1..15) before the new
// domain may write it, so nothing of one domain is ever visible on the
// other domain's port.
module domain_demux_reg #(
    parameter int DW           = 2,
    parameter int SCRUB_CYCLES = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    domain_demux_reg_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FULL  = 2'd1,
        ST_SCRUB = 2'd2
    } state_t;

    localparam logic [3:0] SCRUB_LOAD = 4'(SCRUB_CYCLES);

    state_t          r_st;
    logic [DW-1:0]   r_stage_data;
    logic            r_stage_sel;
    logic            r_last_dom;
    logic [3:0]      r_scrub_cnt;

    // Registered output flags, updated together with the state so that the
    // valids and the scrub indicator come straight from flops.
    logic            r_out0_valid;
    logic            r_out1_valid;
    logic            r_scrubbing;

    logic            w_sink_ready;
    logic            w_same_dom;

    // Ready of the sink that owns the staged word.
    assign w_sink_ready = r_stage_sel ? bus.out1_ready : bus.out0_ready;

    // Incoming word targets the domain that currently owns the stage.
    assign w_same_dom   = (bus.in_sel == r_last_dom);

    // Staging FSM: capture, drain to the owning sink, or scrub on a domain switch.
    // NOTE: sequential state uses non-blocking assignments only, and every
    // register (including the data stage) is cleared by the async reset so a
    // reset mid-transfer or mid-scrub leaves no residue behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st         <= ST_IDLE;
            r_stage_data <= '0;
            r_stage_sel  <= 1'b0;
            r_last_dom   <= 1'b0;
            r_scrub_cnt  <= 4'd0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
            r_scrubbing  <= 1'b0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_same_dom) begin
                            r_stage_data <= bus.in_data;
                            r_stage_sel  <= bus.in_sel;
                            r_out0_valid <= ~bus.in_sel;
                            r_out1_valid <= bus.in_sel;
                            r_st         <= ST_FULL;
                        end else begin
                            // Foreign domain requested: nothing is accepted,
                            // the stage is wiped and the scrub window starts.
                            r_stage_data <= '0;
                            r_scrub_cnt  <= SCRUB_LOAD;
                            r_scrubbing  <= 1'b1;
                            r_st         <= ST_SCRUB;
                        end
                    end
                end

                ST_FULL: begin
                    // Word, select and valid stay frozen until the owning
                    // sink takes it; the data itself is left in the stage
                    // because the next writer must be the same domain.
                    if (w_sink_ready) begin
                        r_out0_valid <= 1'b0;
                        r_out1_valid <= 1'b0;
                        r_st         <= ST_IDLE;
                    end
                end

                ST_SCRUB: begin
                    r_stage_data <= '0;
                    if (r_scrub_cnt == 4'd1) begin
                        // Ownership flips at the end of the window even if
                        // the requester has since gone away or changed its
                        // mind; a further switch simply scrubs again.
                        r_last_dom  <= ~r_last_dom;
                        r_scrub_cnt <= 4'd0;
                        r_scrubbing <= 1'b0;
                        r_st        <= ST_IDLE;
                    end else begin
                        r_scrub_cnt <= r_scrub_cnt - 4'd1;
                    end
                end

                default: begin
                    r_st         <= ST_IDLE;
                    r_stage_data <= '0;
                    r_out0_valid <= 1'b0;
                    r_out1_valid <= 1'b0;
                    r_scrubbing  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: in_ready is deliberately combinational on in_sel so a same-domain
    // word is taken in the cycle it is presented; it is gated by rst_n so it
    // drops the instant reset is asserted, and it is low in FULL so a capture
    // never coincides with a drain.
    assign bus.in_ready   = rst_n && (r_st == ST_IDLE) && w_same_dom;

    // Per-domain masking: a port only ever shows the stage while it owns it.
    assign bus.out0_valid = r_out0_valid;
    assign bus.out1_valid = r_out1_valid;
    assign bus.out0_data  = r_out0_valid ? r_stage_data : '0;
    assign bus.out1_data  = r_out1_valid ? r_stage_data : '0;

    assign bus.cur_dom    = r_last_dom;
    assign bus.scrubbing  = r_scrubbing;

endmodule
